usb_tx_serializer: RTL

- Transmit bit engine directly downstream of the transmit control unit.
- Captures each packet field (SYNC, PID, CRC5, DATA, CRC16) on the controller's load enables, then shifts it out LSB-first, one bit per bit period.
- Applies bit stuffing and NRZI encoding, and drives the D+/D- pair, including SE0 for EOP and J for idle.
- Returns one-clock *_bits_transmitted pulses that advance the controller FSM.

---
 rtl/usb_tx_pkg.sv | 36 +++
 rtl/usb_tx_serializer_if.sv | 44 ++++
 rtl/usb_tx_bit_timer.sv | 22 ++
 rtl/usb_tx_serializer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
// Field lengths, {d_plus,d_minus} line encodings, field ids and serializer states.
package usb_tx_pkg;

    localparam int SYNC_LEN  = 8;
    localparam int PID_LEN   = 8;
    localparam int CRC5_LEN  = 5;
    localparam int CRC16_LEN = 16;
    localparam int DATA_LEN  = 64;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        FLD_SYNC  = 3'd0,
        FLD_PID   = 3'd1,
        FLD_CRC5  = 3'd2,
        FLD_CRC16 = 3'd3,
        FLD_DATA  = 3'd4
    } field_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        STUFF  = 2'd3
    } ser_state_t;

    // A 0 toggles the line between J and K, a 1 holds it.
    function automatic logic [1:0] nrzi_next(input logic [1:0] lvl, input logic b);
        if (b) return lvl;
        return (lvl == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Load/transmit/done handshake between the transmit controller and the serializer.
// The controller drives the master side; the serializer is the slave.
interface usb_tx_serializer_if;
    logic        sync_load_enable;
    logic        pid_load_enable;
    logic        crc5_load_enable;
    logic        crc16_load_enable;
    logic        data_load_enable;
    logic [7:0]  trans_sync;
    logic [7:0]  trans_pid;
    logic [4:0]  trans_crc5;
    logic [15:0] trans_crc16;
    logic [63:0] trans_data;
    logic        sync_transmitting;
    logic        pid_transmitting;
    logic        crc5_transmitting;
    logic        crc16_transmitting;
    logic        data_transmitting;
    logic        eop_transmitting;
    logic        idle_transmitting;
    logic        sync_bits_transmitted;
    logic        pid_bits_transmitted;
    logic        crc5_bits_transmitted;
    logic        crc16_bits_transmitted;
    logic        data_bits_transmitted;

    modport master (
        output sync_load_enable, pid_load_enable, crc5_load_enable, crc16_load_enable, data_load_enable,
        output trans_sync, trans_pid, trans_crc5, trans_crc16, trans_data,
        output sync_transmitting, pid_transmitting, crc5_transmitting, crc16_transmitting, data_transmitting,
        output eop_transmitting, idle_transmitting,
        input  sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted,
        input  crc16_bits_transmitted, data_bits_transmitted
    );

    modport slave (
        input  sync_load_enable, pid_load_enable, crc5_load_enable, crc16_load_enable, data_load_enable,
        input  trans_sync, trans_pid, trans_crc5, trans_crc16, trans_data,
        input  sync_transmitting, pid_transmitting, crc5_transmitting, crc16_transmitting, data_transmitting,
        input  eop_transmitting, idle_transmitting,
        output sync_bits_transmitted, pid_bits_transmitted, crc5_bits_transmitted,
        output crc16_bits_transmitted, data_bits_transmitted
    );
endinterface

// File: rtl/usb_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, end_of_bit high on the last count.
// Latency: restart takes effect next clk (count 0); no backpressure.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    output logic end_of_bit
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;

    assign end_of_bit = (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                   count <= '0;
        else if (restart || end_of_bit) count <= '0;
        else                          count <= count + 1'b1;
    end
endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit bit engine: loads a field, shifts it LSB-first with bit stuffing and NRZI onto D+/D-.
// Latency: first bit on the line 1 clk after *_transmitting; done pulse registered; no backpressure.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_tx_serializer_if.slave   tx,
    output logic                 d_plus,
    output logic                 d_minus,
    output logic                 tx_busy
);
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    ser_state_t  state_q, state_d;
    field_id_t   fld_q, fld_d;
    logic [63:0] shreg_q, shreg_d;
    logic [6:0]  bits_left_q, bits_left_d;
    logic [OW-1:0] ones_q, ones_d, ones_inc;
    logic [1:0]  level_q, level_d;
    logic [4:0]  done_q, done_d;
    logic        end_of_bit;
    logic        tx_match;
    logic        load_any;

    usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .restart    (state_q != SHIFT && state_q != STUFF),
        .end_of_bit (end_of_bit)
    );

    assign load_any = tx.sync_load_enable | tx.pid_load_enable | tx.crc5_load_enable |
                      tx.crc16_load_enable | tx.data_load_enable;
    assign ones_inc = shreg_q[0] ? ones_q + 1'b1 : '0;

    always_comb begin
        tx_match = 1'b0;
        case (fld_q)
            FLD_SYNC:  tx_match = tx.sync_transmitting;
            FLD_PID:   tx_match = tx.pid_transmitting;
            FLD_CRC5:  tx_match = tx.crc5_transmitting;
            FLD_CRC16: tx_match = tx.crc16_transmitting;
            FLD_DATA:  tx_match = tx.data_transmitting;
            default:   tx_match = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        fld_d       = fld_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        ones_d      = ones_q;
        level_d     = level_q;
        done_d      = '0;

        if (tx.eop_transmitting) begin
            // EOP aborts any field in flight without a done pulse.
            state_d = IDLE;
            ones_d  = '0;
        end else if (load_any) begin
            state_d = LOADED;
            if (tx.sync_load_enable) begin
                shreg_d = {56'd0, tx.trans_sync};  bits_left_d = 7'(SYNC_LEN);  fld_d = FLD_SYNC;
            end else if (tx.pid_load_enable) begin
                shreg_d = {56'd0, tx.trans_pid};   bits_left_d = 7'(PID_LEN);   fld_d = FLD_PID;
            end else if (tx.crc5_load_enable) begin
                shreg_d = {59'd0, tx.trans_crc5};  bits_left_d = 7'(CRC5_LEN);  fld_d = FLD_CRC5;
            end else if (tx.crc16_load_enable) begin
                shreg_d = {48'd0, tx.trans_crc16}; bits_left_d = 7'(CRC16_LEN); fld_d = FLD_CRC16;
            end else begin
                shreg_d = tx.trans_data;           bits_left_d = 7'(DATA_LEN);  fld_d = FLD_DATA;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx.idle_transmitting) begin
                        level_d = LINE_J;
                        ones_d  = '0;
                    end
                end
                LOADED: begin
                    if (tx_match) begin
                        state_d = SHIFT;
                        level_d = nrzi_next(level_q, shreg_q[0]);
                    end
                end
                SHIFT: begin
                    if (end_of_bit) begin
                        shreg_d     = shreg_q >> 1;
                        bits_left_d = bits_left_q - 7'd1;
                        ones_d      = ones_inc;
                        if (ones_inc == OW'(STUFF_LIMIT)) begin
                            state_d = STUFF;
                            ones_d  = '0;
                            level_d = nrzi_next(level_q, 1'b0);
                        end else if (bits_left_q == 7'd1) begin
                            state_d        = IDLE;
                            done_d[fld_q]  = 1'b1;
                        end else begin
                            level_d = nrzi_next(level_q, shreg_q[1]);
                        end
                    end
                end
                STUFF: begin
                    // A trailing stuff bit still belongs to the field, so done waits for it.
                    if (end_of_bit) begin
                        if (bits_left_q == 7'd0) begin
                            state_d       = IDLE;
                            done_d[fld_q] = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            level_d = nrzi_next(level_q, shreg_q[0]);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            fld_q       <= FLD_SYNC;
            shreg_q     <= '0;
            bits_left_q <= '0;
            ones_q      <= '0;
            level_q     <= LINE_J;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            fld_q       <= fld_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            ones_q      <= ones_d;
            level_q     <= level_d;
            done_q      <= done_d;
        end
    end

    assign {d_plus, d_minus} = tx.eop_transmitting ? LINE_SE0 : level_q;
    assign tx_busy           = (state_q == SHIFT) || (state_q == STUFF);

    assign tx.sync_bits_transmitted  = done_q[FLD_SYNC];
    assign tx.pid_bits_transmitted   = done_q[FLD_PID];
    assign tx.crc5_bits_transmitted  = done_q[FLD_CRC5];
    assign tx.crc16_bits_transmitted = done_q[FLD_CRC16];
    assign tx.data_bits_transmitted  = done_q[FLD_DATA];
endmodule
